// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared opcodes, FSM state encoding, flag bit positions and
//                index-width helper for the ALU operation sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // ALU opcodes (3 bits)
    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    // Flag bit positions within {overflow, zero, carry}
    localparam int FLG_OVF   = 2;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_CARRY = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Register index width; a single-register file still needs a 1-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_regfile
//  Description : NREG x W register file, two combinational read ports, one
//                synchronous write port, asynchronous active-low clear.
//                Indices at or beyond NREG read zero and never write.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_regfile #(
    parameter int W    = 32,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata
);

    logic [W-1:0] r_regs [NREG];

    // Write port: only an in-range, matching index is updated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NREG; i++) begin
                if (waddr == AW'(i)) begin
                    r_regs[i] <= wdata;
                end
            end
        end
    end

    // Read ports: decoded select so out-of-range indices return zero
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (raddr_a == AW'(i)) rdata_a = r_regs[i];
            if (raddr_b == AW'(i)) rdata_b = r_regs[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Accepts load / ALU commands, reads operands from the internal
//                register file, drives an external combinational ALU, captures
//                result and flags, writes back and returns a response.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int NREG = 4,
    localparam int AW   = idx_width(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [2:0]    cmd_opcode,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_srca,
    input  logic [AW-1:0] cmd_srcb,
    input  logic [W-1:0]  cmd_imm,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_opcode,
    input  logic [W-1:0]  alu_r,
    input  logic          alu_overflow,
    input  logic          alu_zero,
    input  logic          alu_carry,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [W-1:0]  resp_data,
    output logic [2:0]    resp_flags,
    output logic [2:0]    sticky_flags
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_dst;
    logic          r_load;
    logic [W-1:0]  r_alu_a;
    logic [W-1:0]  r_alu_b;
    logic [2:0]    r_alu_opcode;
    logic [W-1:0]  r_resp_data;
    logic [2:0]    r_resp_flags;
    logic [2:0]    r_sticky;

    logic [W-1:0]  w_rd_a;
    logic [W-1:0]  w_rd_b;
    logic [W-1:0]  w_wdata;
    logic          w_we;
    logic [2:0]    w_alu_flags;

    assign cmd_ready    = (r_state == ST_IDLE);
    assign resp_valid   = (r_state == ST_RESP);
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_opcode   = r_alu_opcode;
    assign resp_data    = r_resp_data;
    assign resp_flags   = r_resp_flags;
    assign sticky_flags = r_sticky;

    // Write-back happens on the CAPTURE edge; loads already hold the immediate
    assign w_we    = (r_state == ST_CAPTURE);
    assign w_wdata = r_load ? r_resp_data : alu_r;

    alu_seq_regfile #(
        .W    (W),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (cmd_srca),
        .raddr_b (cmd_srcb),
        .rdata_a (w_rd_a),
        .rdata_b (w_rd_b),
        .we      (w_we),
        .waddr   (r_dst),
        .wdata   (w_wdata)
    );

    // Pack ALU flags into {overflow, zero, carry}
    always_comb begin
        w_alu_flags            = '0;
        w_alu_flags[FLG_OVF]   = alu_overflow;
        w_alu_flags[FLG_ZERO]  = alu_zero;
        w_alu_flags[FLG_CARRY] = alu_carry;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = cmd_load ? ST_CAPTURE : ST_ISSUE;
                end
            end
            ST_ISSUE:   w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch command at accept, capture ALU result, accumulate flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst        <= '0;
            r_load       <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_resp_data  <= '0;
            r_resp_flags <= '0;
            r_sticky     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_dst  <= cmd_dst;
                        r_load <= cmd_load;
                        if (cmd_load) begin
                            r_resp_data <= cmd_imm;
                        end else begin
                            r_alu_a      <= w_rd_a;
                            r_alu_b      <= w_rd_b;
                            r_alu_opcode <= cmd_opcode;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (r_load) begin
                        r_resp_flags <= '0;
                    end else begin
                        r_resp_data  <= alu_r;
                        r_resp_flags <= w_alu_flags;
                        r_sticky     <= r_sticky | w_alu_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
